cv32e40x_wb_stage: RTL and testbench
====================================

CV32E40X_WB_STAGE -- requirements
Module: cv32e40x_wb_stage

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, register file address width.
REQ-002 SHALL have parameter DRAIN_EN, default 1. 1 = a killed outstanding load's late response is discarded. 0 = no DRAIN state.
REQ-003 SHALL have clk  input  1  sole clock, rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ex_wb_pipe_i  input  ex_wb_pipe_t  EX/WB pipeline register. Uses instr_valid, rf_we, rf_waddr, rf_wdata, lsu_en, lsu_mpu_status.
REQ-006 SHALL have ctrl_fsm_i  input  ctrl_fsm_t  controller. Uses kill_wb and halt_wb.
REQ-007 SHALL have lsu_rvalid_i  input  1  load/store response valid.
REQ-008 SHALL have lsu_rdata_i  input  32  aligned, extended load data.
REQ-009 SHALL have lsu_err_i  input  1  bus error, qualified by lsu_rvalid_i.
REQ-010 SHALL have lsu_ready_o  output  1  WB can accept a response.
REQ-011 SHALL have rf_we_wb_o  output  1  register file write enable.
REQ-012 SHALL have rf_waddr_wb_o  output  RF_ADDR_WIDTH  write address.
REQ-013 SHALL have rf_wdata_wb_o  output  32  write data; also forwarded to ID.
REQ-014 SHALL have lsu_err_wb_o  output  1  one-cycle pulse on an erroneous completed response.
REQ-015 SHALL have wb_ready_o  output  1  WB is ready for new data.
REQ-016 SHALL have wb_valid_o  output  1  instruction retires this cycle.

Function
REQ-017 SHALL define instr_valid = ex_wb_pipe_i.instr_valid && !kill_wb && !halt_wb.
REQ-018 SHALL retire a non-LSU instruction combinationally, 0 cycles: wb_valid_o = instr_valid.
REQ-019 SHALL implement state machine states WB_IDLE, WB_WAIT, WB_HOLD, WB_DRAIN, plus a 32-bit data buffer and a 1-bit error buffer.
REQ-020 WB_IDLE, valid LSU instruction without lsu_rvalid_i: SHALL go to WB_WAIT.
REQ-021 WB_IDLE or WB_WAIT, lsu_rvalid_i && instr_valid: SHALL complete in that cycle using lsu_rdata_i and go to / stay in WB_IDLE.
REQ-022 WB_IDLE or WB_WAIT, lsu_rvalid_i && halt_wb && !kill_wb: SHALL capture data and error into the buffers and go to WB_HOLD.
REQ-023 WB_HOLD, !halt_wb: SHALL complete from the buffers and go to WB_IDLE. lsu_ready_o SHALL be 0 in WB_HOLD and 1 in every other state.
REQ-024 kill_wb in WB_HOLD: SHALL invalidate the buffers and go to WB_IDLE.
REQ-025 kill_wb in WB_WAIT: SHALL go to WB_DRAIN when DRAIN_EN=1.
REQ-026 WB_DRAIN: the next lsu_rvalid_i SHALL be consumed with no rf write and no wb_valid_o, then go to WB_IDLE. ex_wb_pipe_i SHALL be ignored while in WB_DRAIN.
REQ-027 kill_wb SHALL take priority over halt_wb and lsu_rvalid_i in the same cycle, except that in WB_DRAIN an arriving response still ends the drain.
REQ-028 Completion of an LSU instruction SHALL assert wb_valid_o for exactly one cycle.
REQ-029 rf_we_wb_o SHALL equal ex_wb_pipe_i.rf_we && completing, and SHALL be forced to 0 if the selected error bit is set or lsu_mpu_status != MPU_OK.
REQ-030 rf_wdata_wb_o SHALL be selected as follows:
  - lsu_en=0: ex_wb_pipe_i.rf_wdata;
  - WB_HOLD: the data buffer;
  - otherwise: lsu_rdata_i.
REQ-031 rf_waddr_wb_o SHALL always equal ex_wb_pipe_i.rf_waddr.
REQ-032 wb_ready_o SHALL equal kill_wb || (!halt_wb && (!lsu_en || completing)). It SHALL be 0 in WB_DRAIN unless kill_wb.
REQ-033 An LSU instruction with lsu_mpu_status != MPU_OK SHALL complete without waiting for a response (no bus transfer was issued).
REQ-034 lsu_rvalid_i in WB_IDLE with no valid LSU instruction is a protocol violation. SHALL ignore it and flag it with an assertion.
REQ-035 At most one response SHALL be outstanding; no second lsu_rvalid_i can occur while in WB_HOLD.

Reset
REQ-036 On rst_n low the block SHALL asynchronously set: state = WB_IDLE, buffers = 0, lsu_err_wb_o = 0.
REQ-037 After reset lsu_ready_o SHALL be 1. rf_we_wb_o and wb_valid_o SHALL be 0 while ex_wb_pipe_i.instr_valid = 0.
REQ-038 Reset asserted mid-WAIT/HOLD/DRAIN SHALL discard the pending response state.

Verification
REQ-039 ALU op, rf_we=1, waddr=5, wdata=0x1234 -> same cycle: wb_valid_o=1, rf_we_wb_o=1, rf_wdata_wb_o=0x1234.
REQ-040 Load issued, rvalid arrives 3 cycles later with rdata=0xDEADBEEF -> wb_ready_o=0 for 3 cycles, then a single-cycle write of 0xDEADBEEF.
REQ-041 Load held by halt_wb, rvalid with 0xA5A5A5A5, halt released after 2 cycles -> WB_HOLD, lsu_ready_o=0, then write of 0xA5A5A5A5 on release.
REQ-042 Load in WB_WAIT, kill_wb pulse, response arrives 2 cycles later -> no rf write, no wb_valid_o, WB_IDLE after the response.
REQ-043 Response with lsu_err_i=1 -> wb_valid_o=1, rf_we_wb_o=0, lsu_err_wb_o pulses 1 cycle.
REQ-044 rst_n asserted in WB_HOLD -> WB_IDLE, lsu_ready_o=1, next ALU op retires normally.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared pipeline types used by the writeback stage and its neighbours.
package cv32e40x_pkg;

  localparam int unsigned REGFILE_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MPU_OK       = 2'd0,
    MPU_RE_FAULT = 2'd1,
    MPU_WR_FAULT = 2'd2
  } mpu_status_e;

  typedef struct packed {
    logic                          instr_valid;
    logic                          rf_we;
    logic [REGFILE_ADDR_WIDTH-1:0] rf_waddr;
    logic [31:0]                   rf_wdata;
    logic                          lsu_en;
    mpu_status_e                   lsu_mpu_status;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic kill_wb;
    logic halt_wb;
  } ctrl_fsm_t;

endpackage

// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: retires ALU results immediately and completes loads/stores
// when their response arrives, buffering it while WB is halted.
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter bit          DRAIN_EN      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  ex_wb_pipe_t              ex_wb_pipe_i,
  input  ctrl_fsm_t                ctrl_fsm_i,
  input  logic                     lsu_rvalid_i,
  input  logic [31:0]              lsu_rdata_i,
  input  logic                     lsu_err_i,
  output logic                     lsu_ready_o,
  output logic                     rf_we_wb_o,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr_wb_o,
  output logic [31:0]              rf_wdata_wb_o,
  output logic                     lsu_err_wb_o,
  output logic                     wb_ready_o,
  output logic                     wb_valid_o
);

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_HOLD  = 2'd2,
    WB_DRAIN = 2'd3
  } wb_state_e;

  wb_state_e   state_q, state_d;
  logic [31:0] data_buf_q;
  logic        err_buf_q;
  logic        lsu_err_q;

  logic        kill, halt, instr_valid, lsu_en, mpu_ok;
  logic        completing, err_sel, buf_capture, buf_clear;

  assign kill        = ctrl_fsm_i.kill_wb;
  assign halt        = ctrl_fsm_i.halt_wb;
  assign instr_valid = ex_wb_pipe_i.instr_valid && !kill && !halt;
  assign lsu_en      = ex_wb_pipe_i.lsu_en;
  assign mpu_ok      = (ex_wb_pipe_i.lsu_mpu_status == MPU_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      lsu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lsu_err_q <= completing && err_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_buf_q <= 32'h0;
      err_buf_q  <= 1'b0;
    end else if (buf_capture) begin
      data_buf_q <= lsu_rdata_i;
      err_buf_q  <= lsu_err_i;
    end else if (buf_clear) begin
      data_buf_q <= 32'h0;
      err_buf_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    completing  = 1'b0;
    err_sel     = 1'b0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (!kill && ex_wb_pipe_i.instr_valid) begin
          // MPU-blocked accesses never reached the bus, so nothing to wait for
          if (!lsu_en || !mpu_ok) begin
            completing = instr_valid;
          end else if (lsu_rvalid_i) begin
            if (halt) begin
              buf_capture = 1'b1;
              state_d     = WB_HOLD;
            end else begin
              completing = 1'b1;
              err_sel    = lsu_err_i;
            end
          end else begin
            state_d = WB_WAIT;
          end
        end
      end

      WB_WAIT: begin
        if (kill) begin
          // A response arriving with the kill is simply dropped here
          state_d = (DRAIN_EN && !lsu_rvalid_i) ? WB_DRAIN : WB_IDLE;
        end else if (lsu_rvalid_i) begin
          if (halt) begin
            buf_capture = 1'b1;
            state_d     = WB_HOLD;
          end else begin
            completing = instr_valid && lsu_en;
            err_sel    = lsu_err_i;
            state_d    = WB_IDLE;
          end
        end
      end

      WB_HOLD: begin
        if (kill) begin
          buf_clear = 1'b1;
          state_d   = WB_IDLE;
        end else if (instr_valid) begin
          completing = 1'b1;
          err_sel    = err_buf_q;
          buf_clear  = 1'b1;
          state_d    = WB_IDLE;
        end
      end

      WB_DRAIN: begin
        if (lsu_rvalid_i) begin
          state_d = WB_IDLE;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    wb_valid_o  = completing;
    rf_we_wb_o  = ex_wb_pipe_i.rf_we && completing && !err_sel && mpu_ok;
    lsu_ready_o = (state_q != WB_HOLD);

    if (!lsu_en) begin
      rf_wdata_wb_o = ex_wb_pipe_i.rf_wdata;
    end else if (state_q == WB_HOLD) begin
      rf_wdata_wb_o = data_buf_q;
    end else begin
      rf_wdata_wb_o = lsu_rdata_i;
    end

    if (state_q == WB_DRAIN) begin
      wb_ready_o = kill;
    end else begin
      wb_ready_o = kill || (!halt && (!lsu_en || completing));
    end
  end

  assign rf_waddr_wb_o = RF_ADDR_WIDTH'(ex_wb_pipe_i.rf_waddr);
  assign lsu_err_wb_o  = lsu_err_q;

`ifndef SYNTHESIS
  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WB_IDLE && lsu_rvalid_i) |-> (ex_wb_pipe_i.instr_valid && lsu_en));

  a_single_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WB_HOLD) |-> !lsu_rvalid_i);
`endif

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Scoreboard bench for the writeback stage: each driven cycle pushes its
// expected outputs, which are popped and compared at the falling edge.
module tb_cv32e40x_wb_stage;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ex_wb_pipe_t pipe;
  ctrl_fsm_t   ctrl;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        lsu_ready, rf_we, lsu_err_wb, wb_ready, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          vld;
    bit          we;
    logic [31:0] wd;
    bit          wr;
    bit          lr;
    bit          err;
  } exp_t;

  exp_t sb[$];

  cv32e40x_wb_stage #(.RF_ADDR_WIDTH(5), .DRAIN_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_wb_pipe_i  (pipe),
    .ctrl_fsm_i    (ctrl),
    .lsu_rvalid_i  (lsu_rvalid),
    .lsu_rdata_i   (lsu_rdata),
    .lsu_err_i     (lsu_err),
    .lsu_ready_o   (lsu_ready),
    .rf_we_wb_o    (rf_we),
    .rf_waddr_wb_o (rf_waddr),
    .rf_wdata_wb_o (rf_wdata),
    .lsu_err_wb_o  (lsu_err_wb),
    .wb_ready_o    (wb_ready),
    .wb_valid_o    (wb_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs after the rising edge, push the expectation,
  // then pop and compare at the falling edge.
  task automatic cyc(input string tag,
                     input bit iv, input bit lsu, input bit we, input logic [31:0] wd,
                     input bit kill, input bit halt,
                     input bit rv, input logic [31:0] rd, input bit er,
                     input bit e_vld, input bit e_we, input logic [31:0] e_wd,
                     input bit e_wr, input bit e_lr, input bit e_err);
    exp_t e;
    @(posedge clk);
    #1;
    pipe.instr_valid = iv;
    pipe.lsu_en      = lsu;
    pipe.rf_we       = we;
    pipe.rf_wdata    = wd;
    ctrl.kill_wb     = kill;
    ctrl.halt_wb     = halt;
    lsu_rvalid       = rv;
    lsu_rdata        = rd;
    lsu_err          = er;
    e.tag = tag; e.vld = e_vld; e.we = e_we; e.wd = e_wd;
    e.wr = e_wr; e.lr = e_lr; e.err = e_err;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_wb_valid"},   {31'd0, wb_valid},   {31'd0, e.vld});
      check({e.tag, "_rf_we"},      {31'd0, rf_we},      {31'd0, e.we});
      check({e.tag, "_wb_ready"},   {31'd0, wb_ready},   {31'd0, e.wr});
      check({e.tag, "_lsu_ready"},  {31'd0, lsu_ready},  {31'd0, e.lr});
      check({e.tag, "_lsu_err_wb"}, {31'd0, lsu_err_wb}, {31'd0, e.err});
      check({e.tag, "_rf_waddr"},   {27'd0, rf_waddr},   32'd5);
      if (e.vld) check({e.tag, "_rf_wdata"}, rf_wdata, e.wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    pipe = '0;
    pipe.rf_waddr = 5'd5;
    pipe.lsu_mpu_status = MPU_OK;
    ctrl = '0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = 32'h0;
    lsu_err    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_lsu_ready",  {31'd0, lsu_ready},  32'd1);
    check("rst_wb_valid",   {31'd0, wb_valid},   32'd0);
    check("rst_rf_we",      {31'd0, rf_we},      32'd0);
    check("rst_lsu_err_wb", {31'd0, lsu_err_wb}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    //   tag          iv lsu we wd            kl hl rv rd            er  vld we wd            wr lr err
    cyc("alu",        1, 0, 1, 32'h1234,     0, 0, 0, 32'h0,        0,  1, 1, 32'h1234,     1, 1, 0);
    cyc("idle0",      0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    cyc("ld_w0",      1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);
    cyc("ld_w1",      1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);
    cyc("ld_w2",      1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);
    cyc("ld_done",    1, 1, 1, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0,  1, 1, 32'hDEADBEEF, 1, 1, 0);
    cyc("idle1",      0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    cyc("hold_rsp",   1, 1, 1, 32'h0,        0, 1, 1, 32'hA5A5A5A5, 0,  0, 0, 32'h0,        0, 1, 0);
    cyc("hold_1",     1, 1, 1, 32'h0,        0, 1, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 0);
    cyc("hold_2",     1, 1, 1, 32'h0,        0, 1, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 0);
    cyc("hold_rel",   1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  1, 1, 32'hA5A5A5A5, 1, 0, 0);
    cyc("idle2",      0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    cyc("kill_wait",  1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);
    cyc("kill_pulse", 1, 1, 1, 32'h0,        1, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);
    cyc("drain_alu",  1, 0, 1, 32'h55,       0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);
    cyc("drain_rsp",  1, 0, 1, 32'h55,       0, 0, 1, 32'hBAD,      0,  0, 0, 32'h0,        0, 1, 0);
    cyc("post_drain", 1, 0, 1, 32'h55,       0, 0, 0, 32'h0,        0,  1, 1, 32'h55,       1, 1, 0);

    cyc("err_rsp",    1, 1, 1, 32'h0,        0, 0, 1, 32'h77,       1,  1, 0, 32'h77,       1, 1, 0);
    cyc("err_pulse",  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 1);
    cyc("err_clear",  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    pipe.lsu_mpu_status = MPU_RE_FAULT;
    cyc("mpu_fault",  1, 1, 1, 32'h0,        0, 0, 0, 32'h0,        0,  1, 0, 32'h0,        1, 1, 0);
    pipe.lsu_mpu_status = MPU_OK;
    cyc("idle3",      0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    cyc("khold_rsp",  1, 1, 1, 32'h0,        0, 1, 1, 32'h11,       0,  0, 0, 32'h0,        0, 1, 0);
    cyc("khold_kill", 1, 1, 1, 32'h0,        1, 1, 0, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0);
    cyc("khold_alu",  1, 0, 1, 32'h99,       0, 0, 0, 32'h0,        0,  1, 1, 32'h99,       1, 1, 0);
    cyc("halt_alu",   1, 0, 1, 32'h99,       0, 1, 0, 32'h0,        0,  0, 0, 32'h0,        0, 1, 0);

    cyc("rhold_rsp",  1, 1, 1, 32'h0,        0, 1, 1, 32'h22,       0,  0, 0, 32'h0,        0, 1, 0);
    cyc("rhold_1",    1, 1, 1, 32'h0,        0, 1, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 0);
    @(posedge clk);
    #1;
    pipe.instr_valid = 1'b0;
    ctrl = '0;
    rst_n = 1'b0;
    #1;
    check("rst_hold_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_hold_wb_valid",  {31'd0, wb_valid},  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rst_alu",    1, 0, 1, 32'hCAFE,     0, 0, 0, 32'h0,        0,  1, 1, 32'hCAFE,     1, 1, 0);
    cyc("idle4",      0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  0, 0, 32'h0,        1, 1, 0);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
